prog_loader_ctrl: RTL

PROG_LOADER_CTRL -- requirements
Module: prog_loader_ctrl

---
 rtl/prog_loader_ctrl.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader_ctrl.sv
// -----------------------------------------------------------------------------
// prog_loader_ctrl
//
// Boot-time program loader. While the CPU is held in reset, it receives a
// framed program image from a byte-oriented serial receiver and writes it
// word by word into instruction memory.
//
// Frame: 0xA5, N (words, 1..255), 2N payload bytes (high byte first per word),
// then one checksum byte when the checksum option is compiled in.
//
// Build option:
//   PROG_LOADER_CHECKSUM_EN  - when defined, a trailing byte equal to the XOR
//                              of all payload bytes is required before DONE.
//                              When undefined, the checksum state and the
//                              accumulator are not built.
//
// Parameters:
//   ADDR_W          instruction-memory address width
//   BASE_ADDR       first write address of every load
//   TIMEOUT_CYCLES  max idle clk cycles between bytes inside a frame
//
// Ports:
//   clk           single clock, rising edge
//   reset         synchronous, active-high reset
//   start         load request (ignored while a load is in progress)
//   rx_valid      one-cycle strobe, rx_byte holds a new byte
//   rx_byte       received byte
//   imem_we       one-cycle instruction-memory write strobe
//   imem_addr     write address
//   imem_wdata    write data
//   cpu_hold      holds the CPU in reset while high
//   busy          high while a frame is being received
//   done          level, last load completed successfully
//   err           level, last load aborted
//   words_loaded  words written in the current or last load
//
// States:
//   IDLE      | out of reset, waiting for the first start
//   WAIT_HDR  | hunting for the 0xA5 header, other bytes discarded
//   WAIT_LEN  | waiting for the word count N
//   WAIT_HI   | waiting for the high byte of the next word
//   WAIT_LO   | waiting for the low byte; also holds through the final write
//             | when there is no checksum stage
//   WAIT_CSUM | waiting for the checksum byte (checksum build only)
//   DONE      | load complete, CPU released
//   ERR       | load aborted, CPU held
// -----------------------------------------------------------------------------
module prog_loader_ctrl #(
  parameter int                ADDR_W         = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = ADDR_W'(16'h0000),
  parameter int                TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        words_loaded
);

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  // The counter only has to reach TIMEOUT_CYCLES-1; the transition to ERR
  // happens on the edge where it would otherwise step to TIMEOUT_CYCLES.
  localparam int                TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_HDR  = 3'd1,
    WAIT_LEN  = 3'd2,
    WAIT_HI   = 3'd3,
    WAIT_LO   = 3'd4,
    WAIT_CSUM = 3'd5,
    DONE      = 3'd6,
    ERR       = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_HDR  = 3'd1,
    WAIT_LEN  = 3'd2,
    WAIT_HI   = 3'd3,
    WAIT_LO   = 3'd4,
    DONE      = 3'd6,
    ERR       = 3'd7
  } state_t;
`endif

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [7:0]        words_q, words_d;
  logic [7:0]        rem_q, rem_d;     // words still to be received
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              tmo_hit;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign tmo_hit = (tmo_q == TMO_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 16'h0000;
      words_q <= 8'h00;
      rem_q   <= 8'h00;
      tmo_q   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      words_q <= words_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    words_d = words_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    // Address and word count advance at the end of the write cycle, so both
    // are stable while imem_we is high.
    if (we_q) begin
      addr_d  = addr_q + ADDR_W'(1);
      words_d = words_q + 8'd1;
    end

    unique case (state_q)
      IDLE, DONE, ERR: begin
        // rx_valid is deliberately not looked at here, so a byte arriving
        // together with start is dropped.
        if (start) begin
          state_d = WAIT_HDR;
          addr_d  = BASE_ADDR;
          words_d = 8'h00;
          tmo_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end

      WAIT_HDR: begin
        // No timeout while hunting for the header.
        tmo_d = '0;
        if (rx_valid && (rx_byte == HDR_BYTE)) begin
          state_d = WAIT_LEN;
        end
      end

      WAIT_LEN: begin
        if (rx_valid) begin
          tmo_d = '0;
          if (rx_byte == 8'h00) begin
            state_d = ERR;
          end else begin
            rem_d   = rx_byte;
            state_d = WAIT_HI;
          end
        end else if (tmo_hit) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      WAIT_HI: begin
        if (rx_valid) begin
          tmo_d          = '0;
          wdata_d[15:8]  = rx_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d         = csum_q ^ rx_byte;
`endif
          state_d        = WAIT_LO;
        end else if (tmo_hit) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      WAIT_LO: begin
`ifndef PROG_LOADER_CHECKSUM_EN
        // Only the final word parks here during its write cycle; the load
        // completes on the following edge.
        if (we_q) begin
          state_d = DONE;
        end else
`endif
        if (rx_valid) begin
          tmo_d         = '0;
          wdata_d[7:0]  = rx_byte;
          we_d          = 1'b1;
          rem_d         = rem_q - 8'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d        = csum_q ^ rx_byte;
          state_d       = (rem_q == 8'd1) ? WAIT_CSUM : WAIT_HI;
`else
          state_d       = (rem_q == 8'd1) ? WAIT_LO : WAIT_HI;
`endif
        end else if (tmo_hit) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      WAIT_CSUM: begin
        // A mismatch does not undo the words already written.
        if (rx_valid) begin
          tmo_d   = '0;
          state_d = (rx_byte == csum_q) ? DONE : ERR;
        end else if (tmo_hit) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = words_q;
  assign done         = (state_q == DONE);
  assign err          = (state_q == ERR);
  assign cpu_hold     = (state_q != DONE);
  assign busy         = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);

endmodule
